// File: rtl/hole_pocket_detector_if.sv
// Per-pixel drawing-request bundle between the bitmap drawers
// and the hole/ball pocket detector.
interface hole_pocket_detector_if;
   logic        startOfFrame;
   logic        drawingRequestBall;
   logic        drawingRequestHole;
   logic        enable;
   logic        pocketed;
   logic        busy;
   logic [10:0] lastOverlapCount;

   modport master (
      output startOfFrame,
      output drawingRequestBall,
      output drawingRequestHole,
      output enable,
      input  pocketed,
      input  busy,
      input  lastOverlapCount
   );

   modport slave (
      input  startOfFrame,
      input  drawingRequestBall,
      input  drawingRequestHole,
      input  enable,
      output pocketed,
      output busy,
      output lastOverlapCount
   );
endinterface

// File: rtl/hole_pocket_detector.sv
// Counts ball/hole overlap pixels per frame and reports a
// debounced pocketed pulse, followed by a frame cooldown.
module hole_pocket_detector #(
   parameter int unsigned OVERLAP_THRESHOLD = 64,
   parameter int unsigned CONSEC_FRAMES     = 2,
   parameter int unsigned COOLDOWN_FRAMES   = 30
) (
   input  logic clk,
   input  logic reset,
   hole_pocket_detector_if.slave bus
);

   typedef enum logic [1:0] {
      SCAN,
      REPORT,
      COOLDOWN
   } state_t;

   state_t      state;
   logic [10:0] pix_cnt;
   logic [10:0] last_cnt;
   logic [3:0]  hit_cnt;
   logic [7:0]  cool_cnt;
   logic        pocketed_q;
   logic        busy_q;

   logic        sof;
   logic        overlap;
   logic        hit_frame;
   logic        pix_sat;
   logic [3:0]  hit_nxt;

   assign sof       = bus.startOfFrame;
   assign overlap   = bus.drawingRequestBall
                    & bus.drawingRequestHole;
   assign hit_frame = pix_cnt >= 11'(OVERLAP_THRESHOLD);
   assign pix_sat   = &pix_cnt;
   assign hit_nxt   = hit_cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SCAN;
         pix_cnt    <= '0;
         last_cnt   <= '0;
         hit_cnt    <= '0;
         cool_cnt   <= '0;
         pocketed_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         pocketed_q <= 1'b0;

         // the startOfFrame pixel already belongs to the new frame
         if (sof) begin
            last_cnt <= pix_cnt;
            pix_cnt  <= {10'd0, overlap};
         end else if (overlap && !pix_sat) begin
            pix_cnt  <= pix_cnt + 11'd1;
         end

         unique case (state)
            SCAN: begin
               if (sof) begin
                  if (!bus.enable || !hit_frame) begin
                     hit_cnt <= '0;
                  end else if (hit_nxt == 4'(CONSEC_FRAMES)) begin
                     hit_cnt    <= '0;
                     state      <= REPORT;
                     pocketed_q <= 1'b1;
                  end else begin
                     hit_cnt <= hit_nxt;
                  end
               end
            end
            REPORT: begin
               state    <= COOLDOWN;
               busy_q   <= 1'b1;
               cool_cnt <= 8'(COOLDOWN_FRAMES);
            end
            COOLDOWN: begin
               if (sof) begin
                  cool_cnt <= cool_cnt - 8'd1;
                  if (cool_cnt == 8'd1) begin
                     state   <= SCAN;
                     busy_q  <= 1'b0;
                     hit_cnt <= '0;
                  end
               end
            end
            default: begin
               state <= SCAN;
            end
         endcase
      end
   end

   assign bus.pocketed         = pocketed_q;
   assign bus.busy             = busy_q;
   assign bus.lastOverlapCount = last_cnt;

endmodule

// File: tb/tb_hole_pocket_detector.sv
// Frame-level reference model and directed scenarios for
// the hole/ball pocket detector.
module tb_hole_pocket_detector;

   localparam int THR    = 64;
   localparam int CONSEC = 2;
   localparam int COOL   = 30;

   logic clk;
   logic reset;

   hole_pocket_detector_if bus();

   hole_pocket_detector #(
      .OVERLAP_THRESHOLD (THR),
      .CONSEC_FRAMES     (CONSEC),
      .COOLDOWN_FRAMES   (COOL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   int dut_pulses;
   bit chk_en;

   // model state: overlaps seen this frame (unbounded),
   // consecutive hit frames, cooldown frames remaining
   int m_cnt;
   int m_hits;
   int m_cool;
   bit m_pend;

   logic        e_poc;
   logic        e_busy;
   logic [10:0] e_last;

   function automatic void check(
      input string       nm,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t",
                  nm, got, exp, $time);
      end
   endfunction

   function automatic void model_step(
      input bit rst,
      input bit sof,
      input bit ov,
      input bit en
   );
      bit was_pend;
      if (rst) begin
         m_cnt  = 0;
         m_hits = 0;
         m_cool = 0;
         m_pend = 0;
         e_poc  = 0;
         e_busy = 0;
         e_last = 0;
         return;
      end
      e_poc    = 0;
      was_pend = m_pend;
      if (m_pend) begin
         m_cool = COOL;
         m_pend = 0;
      end
      if (sof) begin
         e_last = 11'((m_cnt > 2047) ? 2047 : m_cnt);
         if (!was_pend) begin
            if (m_cool > 0) begin
               m_cool--;
               if (m_cool == 0) m_hits = 0;
            end else if (en && m_cnt >= THR) begin
               m_hits++;
               if (m_hits == CONSEC) begin
                  m_hits = 0;
                  e_poc  = 1;
                  m_pend = 1;
               end
            end else begin
               m_hits = 0;
            end
         end
         m_cnt = int'(ov);
      end else begin
         m_cnt += int'(ov);
      end
      e_busy = (m_cool > 0);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("pocketed", 32'(bus.pocketed), 32'(e_poc));
         check("busy", 32'(bus.busy), 32'(e_busy));
         check("lastOverlapCount",
               32'(bus.lastOverlapCount), 32'(e_last));
         if (bus.pocketed === 1'b1) dut_pulses++;
      end
   end

   task automatic cyc(
      input bit rst,
      input bit sof,
      input bit b,
      input bit h,
      input bit en
   );
      reset                  = rst;
      bus.startOfFrame       = sof;
      bus.drawingRequestBall = b;
      bus.drawingRequestHole = h;
      bus.enable             = en;
      @(posedge clk);
      #1;
      model_step(rst, sof, b & h, en);
   endtask

   // sof pixel, n_ov overlapping pixels, then non-overlapping
   // pixels where only one drawer requests
   task automatic frame(
      input int n_ov,
      input bit en_sof,
      input bit en_mid,
      input bit first_ov
   );
      cyc(0, 1, first_ov, first_ov, en_sof);
      for (int i = 0; i < n_ov; i++) cyc(0, 0, 1, 1, en_mid);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, i[0], ~i[0], en_mid);
      end
   endtask

   task automatic fr(input int n_ov);
      frame(n_ov, 1, 1, 0);
   endtask

   task automatic do_reset();
      cyc(1, 1, 1, 1, 1);
   endtask

   int p0;

   initial begin
      total      = 0;
      bad        = 0;
      dut_pulses = 0;
      chk_en     = 0;
      model_step(1, 0, 0, 0);

      // reset (with coincident sof) then check idle outputs
      do_reset();
      chk_en = 1;
      check("rst_pocketed", 32'(bus.pocketed), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_last", 32'(bus.lastOverlapCount), 0);

      // three frames of 100 overlaps
      p0 = dut_pulses;
      fr(100);
      fr(100);
      fr(100);
      check("t1_pulses", dut_pulses - p0, 1);
      check("t1_last", 32'(bus.lastOverlapCount), 100);

      // alternating hit / non-hit frames never report
      do_reset();
      p0 = dut_pulses;
      for (int k = 0; k < 3; k++) begin
         fr(100);
         fr(10);
      end
      fr(0);
      check("t2_pulses", dut_pulses - p0, 0);
      check("t2_last", 32'(bus.lastOverlapCount), 10);

      // threshold boundary 63 / 64
      do_reset();
      p0 = dut_pulses;
      fr(63);
      fr(64);
      check("t3_last63", 32'(bus.lastOverlapCount), 63);
      check("t3_no_pulse", dut_pulses - p0, 0);
      fr(64);
      fr(0);
      check("t3_pulses", dut_pulses - p0, 1);
      check("t3_last64", 32'(bus.lastOverlapCount), 64);

      // cooldown swallows 30 hit frames, then reports again
      do_reset();
      p0 = dut_pulses;
      fr(100);
      fr(100);
      for (int k = 1; k <= 31; k++) begin
         fr(100);
         if (k == 10) check("t4_busy_mid", 32'(bus.busy), 1);
      end
      check("t4_one_pulse", dut_pulses - p0, 1);
      check("t4_busy_off", 32'(bus.busy), 0);
      fr(100);
      fr(0);
      check("t4_pulses", dut_pulses - p0, 2);

      // saturation: 3000 overlaps incl. the sof pixel
      do_reset();
      frame(2999, 1, 1, 1);
      fr(0);
      check("t5_sat", 32'(bus.lastOverlapCount), 2047);

      // reset mid-frame with counter=50, hitCnt=1
      do_reset();
      p0 = dut_pulses;
      fr(100);
      cyc(0, 1, 0, 0, 1);
      for (int i = 0; i < 50; i++) cyc(0, 0, 1, 1, 1);
      do_reset();
      check("t6_pocketed", 32'(bus.pocketed), 0);
      check("t6_busy", 32'(bus.busy), 0);
      check("t6_last", 32'(bus.lastOverlapCount), 0);
      fr(100);
      fr(0);
      check("t6_pulses", dut_pulses - p0, 0);
      check("t6_last100", 32'(bus.lastOverlapCount), 100);

      // enable only matters at sof
      do_reset();
      p0 = dut_pulses;
      frame(100, 1, 0, 0);
      frame(100, 1, 0, 0);
      frame(100, 0, 1, 0);
      fr(100);
      check("t7_no_pulse", dut_pulses - p0, 0);
      fr(0);
      check("t7_pulses", dut_pulses - p0, 1);

      repeat (3) cyc(0, 0, 0, 0, 1);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
